pre_if_stage: RTL



---
 rtl/pre_if_stage_if.sv | 55 +++++
 rtl/pre_if_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_if_stage_if.sv
// -----------------------------------------------------------------------------
// pre_if_stage_if
//
// Instruction-SRAM request/response bus used by the pre-IF stage.
// One read is issued per req/addr_ok handshake; the word returns later with
// data_ok/rdata, in request order.
//
// Signals:
//   inst_ram_req      master -> slave  read request
//   inst_ram_wr       master -> slave  write enable (always 0 for fetch)
//   inst_ram_size     master -> slave  log2 byte count (2 = word)
//   inst_ram_wstrb    master -> slave  byte strobes (unused, 0)
//   inst_ram_wdata    master -> slave  write data (unused, 0)
//   inst_ram_addr     master -> slave  byte address
//   inst_ram_addr_ok  slave -> master  request accepted this cycle
//   inst_ram_data_ok  slave -> master  read data valid this cycle
//   inst_ram_rdata    slave -> master  read data
//
// Modports: master (pre_if_stage), slave (SRAM / bridge).
// -----------------------------------------------------------------------------
interface pre_if_stage_if;
    logic        inst_ram_req;
    logic        inst_ram_wr;
    logic [1:0]  inst_ram_size;
    logic [3:0]  inst_ram_wstrb;
    logic [31:0] inst_ram_wdata;
    logic [31:0] inst_ram_addr;
    logic        inst_ram_addr_ok;
    logic        inst_ram_data_ok;
    logic [31:0] inst_ram_rdata;

    modport master (
        output inst_ram_req,
        output inst_ram_wr,
        output inst_ram_size,
        output inst_ram_wstrb,
        output inst_ram_wdata,
        output inst_ram_addr,
        input  inst_ram_addr_ok,
        input  inst_ram_data_ok,
        input  inst_ram_rdata
    );

    modport slave (
        input  inst_ram_req,
        input  inst_ram_wr,
        input  inst_ram_size,
        input  inst_ram_wstrb,
        input  inst_ram_wdata,
        input  inst_ram_addr,
        output inst_ram_addr_ok,
        output inst_ram_data_ok,
        output inst_ram_rdata
    );
endinterface

// File: rtl/pre_if_stage.sv
// -----------------------------------------------------------------------------
// pre_if_stage
//
// Pre-IF stage of the 5-stage MIPS pipeline. Chooses the next fetch PC
// (sequential, branch redirect, exception / ERET redirect), issues one
// instruction-SRAM read at a time and hands the accepted PC to IF, with the
// instruction word attached when it has already come back. Responses made
// stale by a flush are counted and dropped.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   EX_ENTRY  exception vector
//
// Ports:
//   clk                    clock
//   reset                  asynchronous, active-high reset
//   fs_allowin             IF can accept a PC this cycle
//   pfs_to_fs_valid        bus to IF is valid
//   pfs_to_fs_bus          {inst_ok[64], inst[63:32], pc[31:0]}
//   fs_inst_buff_full      IF already holds a buffered word
//   inst_ram_data_waiting  IF owns an outstanding SRAM response
//   br_bus                 {br_stall, br_taken, br_pc[31:0], br_target[31:0]} from ID
//   inst_ram               instruction SRAM bus (master side)
//   ws_ex, ws_eret         exception / ERET redirects from WB
//   cp0_epc                ERET return address
//
// Build option:
//   PFS_ADEL_EN  when defined, a misaligned next PC is not sent to the SRAM;
//                the stage goes straight to HOLD with a zero word so IF can
//                raise AdEL without a memory access.
// -----------------------------------------------------------------------------
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fs_allowin,
    output logic                  pfs_to_fs_valid,
    output logic [64:0]           pfs_to_fs_bus,
    input  logic                  fs_inst_buff_full,
    input  logic                  inst_ram_data_waiting,
    input  logic [65:0]           br_bus,
    pre_if_stage_if.master        inst_ram,
    input  logic                  ws_ex,
    input  logic                  ws_eret,
    input  logic [31:0]           cp0_epc
);

    localparam logic [1:0] IDLE = 2'd0;  // free to issue a request
    localparam logic [1:0] WAIT = 2'd1;  // request accepted, word not yet seen
    localparam logic [1:0] HOLD = 2'd2;  // word buffered, waiting for IF

    // State
    logic [31:0] prev_pc;
    logic [31:0] req_pc;
    logic [1:0]  state;
    logic [31:0] inst_buf;
    logic        br_buf_valid;
    logic [31:0] br_buf_target;
    logic [1:0]  discard_cnt;

    // Next-state
    logic [31:0] prev_pc_next;
    logic [31:0] req_pc_next;
    logic [1:0]  state_next;
    logic [31:0] inst_buf_next;
    logic        br_buf_valid_next;
    logic [31:0] br_buf_target_next;
    logic [1:0]  discard_cnt_next;

    // Branch bus fields
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_target;

    logic        flush;
    logic [31:0] nextpc;
    logic        br_after_slot;
    logic        br_at_slot;
    logic        fetch_ok;
    logic        ram_req;
    logic        ram_accept;
    logic        adel_take;
    logic        issue;
    logic        drop_resp;
    logic        pfs_data_ok;
    logic        transfer;
    logic        inst_ok;
    logic [31:0] inst;
    logic [1:0]  discard_add;

    assign br_stall  = br_bus[65];
    assign br_taken  = br_bus[64];
    assign br_pc     = br_bus[63:32];
    assign br_target = br_bus[31:0];

    assign flush = ws_ex | ws_eret;

    // The delay slot has already gone to IF: the target is next.
    assign br_after_slot = br_taken && (prev_pc == br_pc + 32'd4);
    // The branch itself was the last PC handed over: the delay slot is next,
    // and the target has to be remembered for the fetch after it.
    assign br_at_slot    = br_taken && (prev_pc == br_pc);

    always_comb begin
        if (ws_ex) begin
            nextpc = EX_ENTRY;
        end else if (ws_eret) begin
            nextpc = cp0_epc;
        end else if (br_buf_valid) begin
            nextpc = br_buf_target;
        end else if (br_after_slot) begin
            nextpc = br_target;
        end else begin
            nextpc = prev_pc + 32'd4;
        end
    end

    // Gating on reset keeps req low while reset is held, yet still lets the
    // first request go out in the first cycle after release.
    assign fetch_ok = !reset && (state == IDLE) && !flush && !br_stall &&
                      !fs_inst_buff_full && (discard_cnt == 2'd0);

`ifdef PFS_ADEL_EN
    logic misaligned;
    assign misaligned = (nextpc[1:0] != 2'b00);
    assign ram_req    = fetch_ok && !misaligned;
    assign adel_take  = fetch_ok && misaligned;
`else
    assign ram_req    = fetch_ok;
    assign adel_take  = 1'b0;
`endif

    assign ram_accept = ram_req && inst_ram.inst_ram_addr_ok;
    // A fetch slot has been consumed, either by the SRAM or by an AdEL bypass.
    assign issue      = ram_accept || adel_take;

    // Response ownership: stale responses first, then IF's outstanding one,
    // and only then our own.
    assign drop_resp   = inst_ram.inst_ram_data_ok && (discard_cnt != 2'd0);
    assign pfs_data_ok = inst_ram.inst_ram_data_ok && (discard_cnt == 2'd0) &&
                         !inst_ram_data_waiting && (state == WAIT);

    assign pfs_to_fs_valid = ((state == WAIT) || (state == HOLD)) && !flush;
    assign transfer        = pfs_to_fs_valid && fs_allowin;

    always_comb begin
        inst_ok = 1'b0;
        inst    = 32'd0;
        if (state == HOLD) begin
            inst_ok = 1'b1;
            inst    = inst_buf;
        end else if ((state == WAIT) && pfs_data_ok) begin
            inst_ok = 1'b1;
            inst    = inst_ram.inst_ram_rdata;
        end
    end

    assign pfs_to_fs_bus = {inst_ok, inst, req_pc};

    assign inst_ram.inst_ram_req   = ram_req;
    assign inst_ram.inst_ram_addr  = nextpc;
    assign inst_ram.inst_ram_wr    = 1'b0;
    assign inst_ram.inst_ram_size  = 2'd2;
    assign inst_ram.inst_ram_wstrb = 4'd0;
    assign inst_ram.inst_ram_wdata = 32'd0;

    // Main FSM and PC bookkeeping
    always_comb begin
        state_next    = state;
        prev_pc_next  = prev_pc;
        req_pc_next   = req_pc;
        inst_buf_next = inst_buf;
        if (flush) begin
            // Next cycle's prev_pc+4 then lands on the redirect target.
            state_next   = IDLE;
            prev_pc_next = nextpc - 32'd4;
        end else begin
            case (state)
                IDLE: begin
                    if (ram_accept) begin
                        req_pc_next = nextpc;
                        state_next  = WAIT;
                    end else if (adel_take) begin
                        req_pc_next   = nextpc;
                        inst_buf_next = 32'd0;
                        state_next    = HOLD;
                    end
                end
                WAIT: begin
                    if (transfer) begin
                        prev_pc_next = req_pc;
                        state_next   = IDLE;
                    end else if (pfs_data_ok) begin
                        inst_buf_next = inst_ram.inst_ram_rdata;
                        state_next    = HOLD;
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        prev_pc_next = req_pc;
                        state_next   = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Branch target buffer for the fetch after a not-yet-fetched delay slot
    always_comb begin
        br_buf_valid_next  = br_buf_valid;
        br_buf_target_next = br_buf_target;
        if (flush) begin
            br_buf_valid_next = 1'b0;
        end else if (issue && br_at_slot) begin
            br_buf_valid_next  = 1'b1;
            br_buf_target_next = br_target;
        end else if (issue && br_buf_valid) begin
            br_buf_valid_next = 1'b0;
        end
    end

    // Stale-response counter: on a flush, count our own in-flight read (if
    // its data has not arrived) and IF's in-flight read (likewise).
    always_comb begin
        discard_add = 2'd0;
        if (flush) begin
            discard_add = {1'b0, (state == WAIT) && !pfs_data_ok} +
                          {1'b0, inst_ram_data_waiting && !inst_ram.inst_ram_data_ok};
        end
        discard_cnt_next = discard_cnt - {1'b0, drop_resp} + discard_add;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc       <= RESET_PC - 32'd4;
            req_pc        <= 32'd0;
            state         <= IDLE;
            inst_buf      <= 32'd0;
            br_buf_valid  <= 1'b0;
            br_buf_target <= 32'd0;
            discard_cnt   <= 2'd0;
        end else begin
            prev_pc       <= prev_pc_next;
            req_pc        <= req_pc_next;
            state         <= state_next;
            inst_buf      <= inst_buf_next;
            br_buf_valid  <= br_buf_valid_next;
            br_buf_target <= br_buf_target_next;
            discard_cnt   <= discard_cnt_next;
        end
    end

endmodule
